// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The state encoding is also visible to checkers through the top's state_dbg port.
package mips_loader_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ADDR_INC = 32'd4;

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words.
// word_valid is combinational on the accept of the 4th byte, so the caller can act on that same edge.
module byte_packer
  import mips_loader_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  byte_cnt_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (accept) begin
      shift_q    <= {shift_q[15:0], in_byte};
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  // Only the three earlier bytes are stored; the 4th is taken straight from the input.
  assign word_valid = accept && (byte_cnt_q == 2'd3);
  assign word       = {shift_q, in_byte};

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: header word count, N instruction words, XOR checksum; writes imem and releases cpu_rst.
// Handshake: a byte transfers on a rising edge when in_valid and in_ready are both high (in_ready already excludes rst).
module inst_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int                DEPTH     = 256,
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              accept;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] n_words_q;
  logic [WORD_W-1:0] csum_q;
  logic [CW-1:0]     word_cnt_q;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign last_word = (32'(word_cnt_q) == (n_words_q - 32'd1));
  assign state_dbg = state_q;

  byte_packer u_packer (
    .clock      (clock),
    .rst        (rst),
    .accept     (accept),
    .in_byte    (in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock) begin
    if (rst) state_q <= ST_HEADER;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HEADER: if (word_valid) begin
        if (word > 32'(DEPTH))  state_d = ST_ERROR;
        else if (word == '0)    state_d = ST_CHECK;
        else                    state_d = ST_LOAD;
      end
      ST_LOAD:   if (word_valid && last_word) state_d = ST_CHECK;
      ST_CHECK:  if (word_valid) state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    cpu_rst    = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state_q)
      ST_HEADER, ST_LOAD, ST_CHECK: in_ready = !rst;
      ST_DONE: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
      end
      ST_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header latch, running checksum, word counter and the registered write port.
  always_ff @(posedge clock) begin
    if (rst) begin
      n_words_q  <= '0;
      csum_q     <= '0;
      word_cnt_q <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (word_valid) begin
        case (state_q)
          ST_HEADER: n_words_q <= word;
          ST_LOAD: begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE_ADDR + 32'(word_cnt_q) * ADDR_INC;
            mem_wdata  <= word;
            csum_q     <= csum_q ^ word;
            word_cnt_q <= word_cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table of whole-stream vectors plus hand-written
// sequences for the N == DEPTH boundary, gapped input with mid-load reset, and reset from DONE.
module tb_inst_mem_loader;
  import mips_loader_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_rst, load_done, load_error;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];

  inst_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_error (load_error),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected {addr, data} queue
  always @(negedge clock) begin
    if (mem_we !== 1'b0) begin
      logic [63:0] e;
      n_writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write we=%b addr=%h data=%h exp=no_write", mem_we, mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e[63:32]);
        check("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic exp_done, input int exp_writes);
    check({tag, "_load_done"},  32'(load_done),  32'(exp_done));
    check({tag, "_load_error"}, 32'(load_error), 32'(!exp_done));
    check({tag, "_cpu_rst"},    32'(cpu_rst),    32'(!exp_done));
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_state"},      32'(state_dbg),  exp_done ? 32'(ST_DONE) : 32'(ST_ERROR));
    check({tag, "_writes"},     32'(n_writes),   32'(exp_writes));
    check({tag, "_pending"},    32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] csum;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] x;
    int nw;

    vecs[0] = '{"nominal",   32'd2,   32'h2008_0005, 32'h0109_4020, 32'h2101_4025, 1'b1};
    vecs[1] = '{"bad_csum",  32'd2,   32'h2008_0005, 32'h0109_4020, 32'h0000_0000, 1'b0};
    vecs[2] = '{"overflow",  32'd257, 32'h0,         32'h0,         32'h0,         1'b0};
    vecs[3] = '{"empty_ok",  32'd0,   32'h0,         32'h0,         32'h0000_0000, 1'b1};
    vecs[4] = '{"empty_bad", 32'd0,   32'h0,         32'h0,         32'h0000_0001, 1'b0};
    vecs[5] = '{"one_word",  32'd1,   32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 1'b1};

    // reset state, sampled while rst is still high after a reset edge
    rst = 1'b1;
    idle(2);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   mem_addr,        BASE);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_cpu_rst",    32'(cpu_rst),    32'd1);
    check("rst_load_done",  32'(load_done),  32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_state",      32'(state_dbg),  32'(ST_HEADER));
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // table-driven whole streams, bytes back-to-back
    for (int v = 0; v < 6; v++) begin
      do_reset();
      n_writes = 0;
      send_word(vecs[v].n, 0);
      if (vecs[v].n <= 32'(DEPTH)) begin
        nw = int'(vecs[v].n);
        if (nw > 0) begin
          check({vecs[v].tag, "_after_header"}, 32'(state_dbg), 32'(ST_LOAD));
          exp_q.push_back({BASE, vecs[v].w0});
          send_word(vecs[v].w0, 0);
        end
        if (nw > 1) begin
          exp_q.push_back({BASE + 32'd4, vecs[v].w1});
          send_word(vecs[v].w1, 0);
        end
        send_word(vecs[v].csum, 0);
      end else begin
        nw = 0;
      end
      check_end(vecs[v].tag, vecs[v].exp_done, nw);
      // terminal states ignore further bytes
      repeat (6) send_byte(8'hA5);
      check({vecs[v].tag, "_sticky_state"}, 32'(state_dbg), vecs[v].exp_done ? 32'(ST_DONE) : 32'(ST_ERROR));
      check({vecs[v].tag, "_sticky_writes"}, 32'(n_writes), 32'(nw));
    end

    // boundary: N == DEPTH is accepted and fills memory up to the last word
    do_reset();
    n_writes = 0;
    x = '0;
    send_word(32'(DEPTH), 0);
    for (int k = 0; k < DEPTH; k++) begin
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(k) * 32'h0001_0003;
      x = x ^ w;
      exp_q.push_back({BASE + 32'(k) * 32'd4, w});
      send_word(w, 0);
    end
    check("full_last_addr", mem_addr, BASE + 32'(DEPTH - 1) * 32'd4);
    send_word(x, 0);
    check_end("full", 1'b1, DEPTH);

    // gapped input, reset after two bytes of word 1
    do_reset();
    n_writes = 0;
    exp_q.push_back({BASE, 32'h2008_0005});
    send_word(32'd2, 3);
    send_word(32'h2008_0005, 3);
    idle($urandom_range(1, 3));
    send_byte(8'h01);
    idle($urandom_range(0, 3));
    send_byte(8'h09);
    idle(2);
    check("midrst_partial_no_write", 32'(n_writes), 32'd1);
    do_reset();
    check("midrst_state",   32'(state_dbg), 32'(ST_HEADER));
    check("midrst_cpu_rst", 32'(cpu_rst),   32'd1);
    check("midrst_writes",  32'(n_writes),  32'd1);
    n_writes = 0;
    exp_q.push_back({BASE, 32'h2008_0005});
    exp_q.push_back({BASE + 32'd4, 32'h0109_4020});
    send_word(32'd2, 2);
    send_word(32'h2008_0005, 2);
    send_word(32'h0109_4020, 2);
    send_word(32'h2101_4025, 2);
    check_end("replay", 1'b1, 2);

    // reset from DONE holds the core again
    rst = 1'b1;
    @(posedge clock);
    #1;
    check("done_rst_cpu_rst",   32'(cpu_rst),   32'd1);
    check("done_rst_load_done", 32'(load_done), 32'd0);
    check("done_rst_state",     32'(state_dbg), 32'(ST_HEADER));
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
